fetch_decode_buf: RTL and testbench
===================================

# fetch_decode_buf

Two-entry registered instruction buffer between the fetch stage and the decode stage of the pipelined RV32I core. It replaces a bare IF/ID register. Fetch pushes {instruction, PC, PC+4} with a valid/ready handshake, and decode pops with its own valid/ready handshake. A decode stall therefore never needs to freeze fetch on the same cycle. It also applies branch/jump flushes and presents a NOP bubble whenever nothing valid is held.

## Interface
Parameters:
- WIDTH, 32, data/address width of instruction and PC fields.
- DEPTH, 2, entry count; fixed at 2 (the only supported value).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- InstrF  input  WIDTH  instruction word from instruction memory.
- PCF  input  WIDTH  PC of InstrF.
- PCPlus4F  input  WIDTH  PCF + 4.
- ValidF  input  1  fetch is presenting a real instruction this cycle.
- ReadyF  output  1  buffer accepts a push this cycle; drives fetch `en`.
- FlushD  input  1  discard all held and incoming instructions (taken branch/jump resolved in execute).
- InstrD  output  WIDTH  head instruction, or NOP when empty.
- PCD  output  WIDTH  head PC, or 0 when empty.
- PCPlus4D  output  WIDTH  head PC+4, or 0 when empty.
- ValidD  output  1  head entry valid.
- ReadyD  input  1  decode consumes the head this cycle (the inverse of StallD).

## Operation
- Storage: 2 entries of {instr, pc, pcplus4}, a 1-bit head pointer, a 1-bit tail pointer and a 2-bit count (0..2).
- push = ValidF & ReadyF & ~FlushD; pop = ValidD & ReadyD & ~FlushD.
- ReadyF = (count != 2). It depends only on registered state, so there is no combinational path from ReadyD to ReadyF.
- ValidD = (count != 0).
- On push: write tail entry, then tail <= tail+1 (wraps 1->0).
- On pop: head <= head+1 (wraps).
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push and pop in the same cycle at count==1 is legal. Count stays 1 and the new entry becomes head.
- At count==2, ReadyF=0, so a push is impossible. A pop alone frees a slot, and ReadyF=1 on the next cycle.
- At count==0, ValidD=0 and a pop is impossible. A push makes ValidD=1 on the next cycle; there is no fall-through.
- FlushD=1 has priority over push and pop. Next cycle: count=0, head=tail=0, ValidD=0, ReadyF=1. Entry contents need not be cleared.
- Empty outputs: InstrD=32'h00000013 (addi x0,x0,0), PCD=0, PCPlus4D=0. These are selected combinationally from count==0.
- Outputs when non-empty: InstrD/PCD/PCPlus4D = entry[head], a direct register read.

## Timing
- Latency: 1 cycle. An instruction pushed at edge N is visible on InstrD after edge N, provided older entries have drained.
- Throughput: 1 instruction/cycle sustained while ReadyD=1.
- Reset: rst=1 at an edge sets count=0, head=0 and tail=0. After that edge: ValidD=0, ReadyF=1, InstrD=32'h00000013, PCD=0, PCPlus4D=0.
- Reset asserted mid-operation discards all entries, the same as a flush. rst has priority over FlushD, push and pop.
- FlushD asserted at edge N: the first instruction accepted after the flush is the one pushed at edge N+1 or later.
- ReadyD may change every cycle. Data at the head is stable while ValidD=1 and ReadyD=0.

## Structure
- Shared package `pipe_pkg`:
  - constant NOP_INSTR = 32'h00000013;
  - typedef struct packed fd_entry_t {instr, pc, pcplus4}, each WIDTH bits.
- One natural sub-module: `skid_fifo2`. It is a generic 2-entry FIFO of fd_entry_t with push/pop/flush, count, and full/empty flags. `fetch_decode_buf` wraps it with handshake qualification and NOP/zero bubble muxing.
- Expected size is roughly 150–250 lines of RTL in total.

## Test plan
- Reset: hold rst 2 cycles with ValidF=1. Required: ValidD=0, ReadyF=1, InstrD=32'h00000013, PCD=0. The first push after reset (PCF=0x0, InstrF=0x00500093) appears on the next cycle with ValidD=1.
- Streaming: ReadyD=1; push PC 0x0, 0x4, 0x8, 0xC back-to-back. Required: ValidD=1 every cycle from the second cycle, PCD follows 0x0, 0x4, 0x8, 0xC one cycle behind, and ReadyF stays 1.
- Backpressure/full:
  - ReadyD=0; push 0x10 then 0x14. Required: ReadyF=0 after the second push, and a third offered 0x18 is not accepted.
  - Then ReadyD=1 for 1 cycle. Required: PCD 0x10 -> 0x14, ReadyF=1, and 0x18 is accepted the cycle after.
- Simultaneous push/pop at count==1: head 0x20, push 0x24 with ReadyD=1. Required: count stays 1 and PCD=0x24 next cycle.
- Flush priority: count==2 (0x30, 0x34), FlushD=1 with ValidF=1 (0x38) and ReadyD=1. Required next cycle: ValidD=0, InstrD=NOP, ReadyF=1, and 0x38 is never output.
- Wrap-around: 10 pushes/pops with random ReadyD. Required: output PC order matches input order exactly, with no loss or duplication across pointer wraps.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the fetch/decode boundary of the RV32I core.
package pipe_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } fd_entry_t;
endpackage

// File: rtl/skid_fifo2.sv
// Generic two-entry FIFO with flush; push when full and pop when empty are ignored.
module skid_fifo2
  import pipe_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fd_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  T           wdata_i,
  output T           rdata_o,
  output logic [1:0] count_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  T           mem_q [2];
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign rdata_o = mem_q[head_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (do_push) tail_d = ~tail_q;
      if (do_pop)  head_d = ~head_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[tail_q] <= wdata_i;
  end
endmodule

// File: rtl/fetch_decode_buf.sv
// Two-entry IF/ID buffer: handshake qualification, flush, and NOP bubble on empty.
module fetch_decode_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] InstrF,
  input  logic [WIDTH-1:0] PCF,
  input  logic [WIDTH-1:0] PCPlus4F,
  input  logic             ValidF,
  output logic             ReadyF,
  input  logic             FlushD,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD,
  input  logic             ReadyD
);
  fd_entry_t  wr_ent, hd_ent;
  logic [1:0] cnt;
  logic       full, empty, push, pop, bubble;

  // ReadyF comes straight from registered occupancy, never from ReadyD.
  assign ReadyF = ~full;
  assign ValidD = ~empty;
  assign push   = ValidF & ReadyF & ~FlushD;
  assign pop    = ValidD & ReadyD & ~FlushD;
  assign wr_ent = '{instr: InstrF, pc: PCF, pcplus4: PCPlus4F};

  skid_fifo2 #(.DEPTH(DEPTH), .T(fd_entry_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (FlushD),
    .wdata_i (wr_ent),
    .rdata_o (hd_ent),
    .count_o (cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bubble   = (cnt == 2'd0);
  assign InstrD   = bubble ? NOP_INSTR : hd_ent.instr;
  assign PCD      = bubble ? '0 : hd_ent.pc;
  assign PCPlus4D = bubble ? '0 : hd_ent.pcplus4;
endmodule

// File: tb/tb_fetch_decode_buf.sv
// Scoreboard bench: stimulus predicts accepted entries, monitor checks each pop in order.
module tb_fetch_decode_buf;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] InstrF = '0, PCF = '0, PCPlus4F = '0;
  logic        ValidF = 1'b0, FlushD = 1'b0, ReadyD = 1'b0;
  logic        ReadyF, ValidD;
  logic [31:0] InstrD, PCD, PCPlus4D;

  fetch_decode_buf #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .ValidF(ValidF), .ReadyF(ReadyF), .FlushD(FlushD), .InstrD(InstrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .ReadyD(ReadyD)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  int        occ    = 0;
  bit        chk_en = 1'b0;
  fd_entry_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model is just an occupancy count plus an in-order queue.
  task automatic step(input logic r, input logic vf, input logic fl, input logic rd,
                      input logic [31:0] pc, input logic [31:0] ins);
    bit pu, po;
    @(negedge clk);
    if (chk_en) begin
      chk("ReadyF", 32'(ReadyF), 32'(occ != 2));
      chk("ValidD", 32'(ValidD), 32'(occ != 0));
    end
    rst = r; ValidF = vf; FlushD = fl; ReadyD = rd;
    PCF = pc; PCPlus4F = pc + 32'd4; InstrF = ins;
    if (r || fl) begin
      occ = 0;
      exp_q.delete();
    end else begin
      pu = vf && (occ != 2);
      po = rd && (occ != 0);
      if (pu) exp_q.push_back('{instr: ins, pc: pc, pcplus4: pc + 32'd4});
      occ = occ + int'(pu) - int'(po);
    end
    if (r) chk_en = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
  endtask

  // Monitor: checks bubble outputs while empty and the head against the scoreboard on each pop.
  always @(negedge clk) begin
    fd_entry_t e;
    #1;
    if (chk_en && !rst) begin
      if (!ValidD) begin
        chk("empty_InstrD", InstrD, NOP_INSTR);
        chk("empty_PCD", PCD, 32'h0);
        chk("empty_PCPlus4D", PCPlus4D, 32'h0);
      end else if (ReadyD && !FlushD) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got PCD %08h expected no valid entry", PCD);
        end else begin
          e = exp_q.pop_front();
          chk("pop_PCD", PCD, e.pc);
          chk("pop_InstrD", InstrD, e.instr);
          chk("pop_PCPlus4D", PCPlus4D, e.pcplus4);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc_ctr;
    // Reset held two cycles with fetch offering
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0050_0093);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0050_0093);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0050_0093);
    settle();
    chk("first_ValidD", 32'(ValidD), 32'd1);
    chk("first_PCD", PCD, 32'h0);
    chk("first_InstrD", InstrD, 32'h0050_0093);
    drain(2);

    // Streaming
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'(i * 4), $urandom);
    drain(2);

    // Backpressure up to full, then one pop
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, $urandom);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h14, $urandom);
    settle();
    chk("full_ReadyF", 32'(ReadyF), 32'd0);
    chk("full_PCD", PCD, 32'h10);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h18, 32'hDEAD_0018);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h18, 32'hDEAD_0018);
    settle();
    chk("afterpop_PCD", PCD, 32'h14);
    chk("afterpop_ReadyF", 32'(ReadyF), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h18, 32'h0000_0018);
    drain(3);

    // Simultaneous push/pop at one entry
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, $urandom);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h24, $urandom);
    settle();
    chk("pushpop_PCD", PCD, 32'h24);
    chk("pushpop_ReadyF", 32'(ReadyF), 32'd1);
    drain(2);

    // Flush with a full buffer and a concurrent offer
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h30, $urandom);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h34, $urandom);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h38, $urandom);
    settle();
    chk("flush_ValidD", 32'(ValidD), 32'd0);
    chk("flush_InstrD", InstrD, NOP_INSTR);
    chk("flush_ReadyF", 32'(ReadyF), 32'd1);
    drain(2);

    // Randomized traffic across many pointer wraps, with occasional flush/reset
    pc_ctr = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0), 1'($urandom), pc_ctr, $urandom);
      pc_ctr += 32'd4;
    end
    drain(4);
    settle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
